// File: rtl/lifo_pkg.sv
// ============================================================================
// Module      : lifo_pkg
// Description : Shared constants and types for the LIFO pop-to-stream block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lifo_pkg;

  localparam int LIFO_WIDTH = 32;
  localparam int CNT_W      = 16;

  typedef logic [1:0] occ_t;

endpackage

`default_nettype wire

// File: rtl/lifo_out_buf.sv
// ============================================================================
// Module      : lifo_out_buf
// Description : Two-entry FIFO holding popped words until the stream takes
//               them; head and occupancy come straight from registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lifo_out_buf
  import lifo_pkg::*;
#(
  parameter int WIDTH = LIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] head,
  output occ_t             occ
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  occ_t             r_occ;

  // The caller guarantees wr only when not full (or reading) and rd only when
  // not empty, so a write into a full buffer always lands on the departing head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_occ    <= '0;
    end else begin
      if (wr) begin
        r_mem[r_wptr] <= wdata;
        r_wptr        <= ~r_wptr;
      end
      if (rd) begin
        r_rptr <= ~r_rptr;
      end
      case ({wr, rd})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign head = r_mem[r_rptr];
  assign occ  = r_occ;

endmodule

`default_nettype wire

// File: rtl/lifo_pop_stream.sv
// ============================================================================
// Module      : lifo_pop_stream
// Description : Pops words off a LIFO and presents them as a valid/ready
//               stream through a two-entry registered buffer.
//               Optional macro LIFO_POP_STREAM_CNT_EN adds a 16-bit pop_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lifo_pop_stream
  import lifo_pkg::*;
#(
  parameter int WIDTH     = LIFO_WIDTH,
  parameter int BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             lifo_empty,
  input  logic             lifo_push,
  input  logic [WIDTH-1:0] lifo_data,
  output logic             lifo_pop,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output occ_t             occ
`ifdef LIFO_POP_STREAM_CNT_EN
  ,
  output logic [CNT_W-1:0] pop_cnt
`endif
);

  localparam occ_t C_FULL = occ_t'(BUF_DEPTH);

  logic w_space;
  logic w_xfer;

  assign w_xfer  = m_valid & m_ready;
  assign w_space = (occ < C_FULL) | ((occ == C_FULL) & w_xfer);

  // Push wins at the stack, so a pop alongside it would be silently dropped.
  assign lifo_pop = rst_n & en & ~lifo_empty & ~lifo_push & w_space;
  assign m_valid  = (occ != 2'd0);

  lifo_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (lifo_pop),
    .wdata (lifo_data),
    .rd    (w_xfer),
    .head  (m_data),
    .occ   (occ)
  );

`ifdef LIFO_POP_STREAM_CNT_EN
  logic [CNT_W-1:0] r_pop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_cnt <= '0;
    end else if (lifo_pop) begin
      r_pop_cnt <= r_pop_cnt + CNT_W'(1);
    end
  end

  assign pop_cnt = r_pop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lifo_pop_stream.sv
// ============================================================================
// Module      : tb_lifo_pop_stream
// Description : Directed self-checking bench with a behavioural stack model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lifo_pop_stream;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         lifo_empty;
  logic         lifo_push;
  logic [W-1:0] lifo_data;
  logic         lifo_pop;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic [1:0]   occ;
`ifdef LIFO_POP_STREAM_CNT_EN
  logic [15:0]  pop_cnt;
`endif

  logic [W-1:0] push_data;
  logic [W-1:0] stk [0:15];
  logic [4:0]   sp = 5'd0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lifo_pop_stream #(.WIDTH(W), .BUF_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .lifo_empty (lifo_empty),
    .lifo_push  (lifo_push),
    .lifo_data  (lifo_data),
    .lifo_pop   (lifo_pop),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .occ        (occ)
`ifdef LIFO_POP_STREAM_CNT_EN
    ,
    .pop_cnt    (pop_cnt)
`endif
  );

  // Stack model: push has priority over pop, like the real stack.
  always @(posedge clk) begin
    if (lifo_push) begin
      stk[sp] <= push_data;
      sp      <= sp + 5'd1;
    end else if (lifo_pop) begin
      sp <= sp - 5'd1;
    end
  end

  assign lifo_empty = (sp == 5'd0);
  assign lifo_data  = (sp != 5'd0) ? stk[sp - 5'd1] : '0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    lifo_push = 1'b1;
    push_data = w;
    cycle();
    lifo_push = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; lifo_push = 1'b0; push_data = '0; m_ready = 1'b1;

    // Stack A,B,C with C on top, loaded while held in reset
    cycle();
    push_word(32'hAAAA_0001);
    push_word(32'hBBBB_0002);
    push_word(32'hCCCC_0003);
    en = 1'b1;
    #1;
    check("rst_pop", {31'd0, lifo_pop}, 32'd0);
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_occ", {30'd0, occ}, 32'd0);
    check("rst_data", m_data, 32'd0);

    // Three back-to-back pops stream out C,B,A
    cycle();
    rst_n = 1'b1;
    #1;
    check("abc_pop0", {31'd0, lifo_pop}, 32'd1);
    cycle();
    check("abc_d0", m_data, 32'hCCCC_0003);
    check("abc_v0", {31'd0, m_valid}, 32'd1);
    check("abc_pop1", {31'd0, lifo_pop}, 32'd1);
    cycle();
    check("abc_d1", m_data, 32'hBBBB_0002);
    check("abc_pop2", {31'd0, lifo_pop}, 32'd1);
    cycle();
    check("abc_d2", m_data, 32'hAAAA_0001);
    check("abc_occ2", {30'd0, occ}, 32'd1);
    check("abc_pop3", {31'd0, lifo_pop}, 32'd0);
    cycle();
    check("abc_idle", {31'd0, m_valid}, 32'd0);

    // Five words with consumer stalled: two pops then backpressure
    en = 1'b0;
    for (int i = 0; i < 5; i++) push_word(32'h5000_0000 + i);
    m_ready = 1'b0;
    en = 1'b1;
    #1;
    check("bp_pop0", {31'd0, lifo_pop}, 32'd1);
    cycle();
    check("bp_pop1", {31'd0, lifo_pop}, 32'd1);
    check("bp_occ1", {30'd0, occ}, 32'd1);
    cycle();
    check("bp_occ2", {30'd0, occ}, 32'd2);
    check("bp_stall", {31'd0, lifo_pop}, 32'd0);
    cycle();
    check("bp_hold", m_data, 32'h5000_0004);
    check("bp_stall2", {31'd0, lifo_pop}, 32'd0);
    m_ready = 1'b1;
    #1;
    check("bp_resume", {31'd0, lifo_pop}, 32'd1);
    cycle();
    check("full_d3", m_data, 32'h5000_0003);
    check("full_occ", {30'd0, occ}, 32'd2);
    check("full_pop", {31'd0, lifo_pop}, 32'd1);
    cycle();
    check("full_d2", m_data, 32'h5000_0002);
    check("full_occ_b", {30'd0, occ}, 32'd2);
    cycle();
    check("full_d1", m_data, 32'h5000_0001);
    check("full_last", {31'd0, lifo_pop}, 32'd0);
    cycle();
    check("full_d0", m_data, 32'h5000_0000);
    cycle();
    check("full_drain", {30'd0, occ}, 32'd0);

    // Push collides with pop: pop deferred one cycle, takes the new word
    en = 1'b0;
    push_word(32'hDEAD_0001);
    en = 1'b1;
    lifo_push = 1'b1;
    push_data = 32'hBEEF_0002;
    #1;
    check("push_block", {31'd0, lifo_pop}, 32'd0);
    cycle();
    lifo_push = 1'b0;
    #1;
    check("push_after", {31'd0, lifo_pop}, 32'd1);
    cycle();
    check("push_new", m_data, 32'hBEEF_0002);
    cycle();
    check("push_old", m_data, 32'hDEAD_0001);
    cycle();

    // en drops mid-stream: popping stops at once, buffer still drains
    en = 1'b0;
    push_word(32'h1111_0001);
    push_word(32'h2222_0002);
    en = 1'b1;
    cycle();
    check("en_d", m_data, 32'h2222_0002);
    en = 1'b0;
    #1;
    check("en_off_pop", {31'd0, lifo_pop}, 32'd0);
    cycle();
    check("en_drain", {31'd0, m_valid}, 32'd0);
    en = 1'b1;
    cycle();
    cycle();
    check("en_empty", {31'd0, lifo_empty}, 32'd1);

    // Reset while full discards buffered words immediately
    en = 1'b0;
    push_word(32'h3000_0001);
    push_word(32'h3000_0002);
    push_word(32'h3000_0003);
    m_ready = 1'b0;
    en = 1'b1;
    cycle();
    cycle();
    check("pre_rst_occ", {30'd0, occ}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, m_valid}, 32'd0);
    check("arst_occ", {30'd0, occ}, 32'd0);
    check("arst_pop", {31'd0, lifo_pop}, 32'd0);
    cycle();
    rst_n = 1'b1;
    #1;
    check("rel_pop", {31'd0, lifo_pop}, 32'd1);
    cycle();
    check("rel_d", m_data, 32'h3000_0001);
    check("rel_occ", {30'd0, occ}, 32'd1);

`ifdef LIFO_POP_STREAM_CNT_EN
    // Counter wrap: 0x10000 pops with the stream free-running
    rst_n = 1'b0;
    en = 1'b0;
    m_ready = 1'b1;
    #1;
    rst_n = 1'b1;
    check("cnt_rst", {16'd0, pop_cnt}, 32'd0);
    en = 1'b1;
    for (int i = 0; i < 32'h10000; i++) begin
      lifo_push = 1'b1;
      push_data = i;
      cycle();
      lifo_push = 1'b0;
      #1;
      cycle();
    end
    cycle();
    check("cnt_wrap", {16'd0, pop_cnt}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
